// File: rtl/imem_load_ctrl.sv
// Instruction-memory program loader: streams loader words into IMEM, then flushes and releases the CPU.
// Optional build macro IMEM_LOAD_CHECKSUM_EN adds an ld_csum input and a checksum gate on the load.
module imem_load_ctrl #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
`ifdef IMEM_LOAD_CHECKSUM_EN
    input  logic [31:0]       ld_csum,
`endif
    output logic              ld_ready,
    input  logic              run_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    state_t          state;
    state_t          state_nxt;
    // One bit wider than the address so a DEPTH-word load ends without wrapping to 0.
    logic [ADDR_W:0] counter;
    logic [ADDR_W:0] limit;
    logic            count_ok;
    logic            can_start;
    logic            start_ok;
    logic            start_bad;
    logic            accept;
    logic            last;
    logic            csum_ok;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] csum_acc;
    logic [31:0] csum_exp;
    assign csum_ok = ((csum_acc + ld_data) == csum_exp);
`else
    assign csum_ok = 1'b1;
`endif

    assign count_ok  = (ld_count != '0) && (ld_count <= MAX_COUNT);
    assign can_start = (state == S_IDLE) || (state == S_RUN);
    assign start_ok  = can_start && ld_start && count_ok;
    assign start_bad = can_start && ld_start && !count_ok;
    assign accept    = (state == S_LOAD) && ld_valid;
    assign last      = accept && (counter == limit - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ld_start outranks run_req in IDLE; a checksum miss drops back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ld_start) begin
                    if (count_ok) state_nxt = S_LOAD;
                end else if (run_req) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_LOAD: begin
                if (last) state_nxt = csum_ok ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: state_nxt = S_RUN;
            S_RUN: begin
                if (start_ok) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = fetch_addr;
        cpu_stall = 1'b1;
        cpu_rst   = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_wdata = ld_data;
                mem_addr  = counter[ADDR_W-1:0];
                busy      = 1'b1;
            end
            S_FLUSH: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
            end
            S_RUN:   cpu_stall = 1'b0;
            default: ;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            limit   <= '0;
            err     <= 1'b0;
        end else begin
            err <= start_bad || (last && !csum_ok);
            if (start_ok) begin
                counter <= '0;
                limit   <= ld_count;
            end else if (accept) begin
                counter <= counter + ONE;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_acc <= '0;
            csum_exp <= '0;
        end else if (start_ok) begin
            csum_acc <= '0;
            csum_exp <= ld_csum;
        end else if (accept) begin
            csum_acc <= csum_acc + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural instruction memory behind the write port.
// Defining IMEM_LOAD_CHECKSUM_EN also enables the checksum scenarios.
module tb_imem_load_ctrl;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_start;
    logic [6:0]  ld_count;
    logic        ld_valid;
    logic [31:0] ld_data;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] ld_csum;
`endif
    logic        ld_ready;
    logic        run_req;
    logic [5:0]  fetch_addr;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        cpu_rst;
    logic        busy;
    logic        err;
    logic [1:0]  dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;
    int we_cnt  = 0;
    int we0;
    logic [31:0] mem [64];

    imem_load_ctrl #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_count   (ld_count),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .ld_csum    (ld_csum),
`endif
        .ld_ready   (ld_ready),
        .run_req    (run_req),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural IMEM behind the write port
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [6:0] cnt);
        ld_start = 1'b1;
        ld_count = cnt;
        step();
        ld_start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        ld_valid = 1'b1;
        ld_data  = w;
        step();
        ld_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ld_start = 1'b0; ld_count = '0; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        run_req = 1'b0; fetch_addr = 6'd5;
`ifdef IMEM_LOAD_CHECKSUM_EN
        ld_csum = '0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        #3;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step(); step();
        rst_n = 1'b1; ld_valid = 1'b0;
        step();

        // run_req without load: IDLE -> FLUSH -> RUN
        check("idle_mem_addr", 32'(mem_addr), 32'd5);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("flush_state", 32'(dbg_state), 32'(FLUSH));
        check("flush_cpu_rst", 32'(cpu_rst), 32'd1);
        check("flush_cpu_stall", 32'(cpu_stall), 32'd1);
        check("flush_busy", 32'(busy), 32'd1);
        step();
        check("run_state", 32'(dbg_state), 32'(RUN));
        check("run_cpu_stall", 32'(cpu_stall), 32'd0);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_mem_addr5", 32'(mem_addr), 32'd5);
        fetch_addr = 6'd9;
        #1;
        check("run_mem_addr9", 32'(mem_addr), 32'd9);

        // 3-word load from RUN with a two-cycle valid gap after the first word
        we0 = we_cnt;
        start_load(7'd3);
        check("ld3_state", 32'(dbg_state), 32'(LOAD));
        check("ld3_ready", 32'(ld_ready), 32'd1);
        check("ld3_stall", 32'(cpu_stall), 32'd1);
        ld_valid = 1'b1; ld_data = 32'h0000_2083;
        #1;
        check("ld3_we0", 32'(mem_we), 32'd1);
        check("ld3_addr0", 32'(mem_addr), 32'd0);
        check("ld3_wdata0", mem_wdata, 32'h0000_2083);
        step();
        ld_valid = 1'b0; ld_start = 1'b1; ld_count = 7'd5;
        #1;
        check("ld3_gap_we", 32'(mem_we), 32'd0);
        check("ld3_gap_addr", 32'(mem_addr), 32'd1);
        step();
        ld_start = 1'b0;
        step();
        check("ld3_gap_state", 32'(dbg_state), 32'(LOAD));
        ld_valid = 1'b1; ld_data = 32'h0080_2103;
        #1;
        check("ld3_addr1", 32'(mem_addr), 32'd1);
        step();
        ld_data = 32'h00C0_2183;
        #1;
        check("ld3_addr2", 32'(mem_addr), 32'd2);
        step();
        check("ld3_flush_state", 32'(dbg_state), 32'(FLUSH));
        check("ld3_flush_we", 32'(mem_we), 32'd0);
        check("ld3_flush_ready", 32'(ld_ready), 32'd0);
        check("ld3_flush_cpu_rst", 32'(cpu_rst), 32'd1);
        ld_valid = 1'b0;
        step();
        check("ld3_run_state", 32'(dbg_state), 32'(RUN));
        check("ld3_we_cycles", 32'(we_cnt - we0), 32'd3);
        check("ld3_mem0", mem[0], 32'h0000_2083);
        check("ld3_mem1", mem[1], 32'h0080_2103);
        check("ld3_mem2", mem[2], 32'h00C0_2183);

        // Invalid count while running: err pulse, stay RUN
        start_load(7'd0);
        check("run_bad_err", 32'(err), 32'd1);
        check("run_bad_state", 32'(dbg_state), 32'(RUN));
        step();
        check("run_bad_err_clr", 32'(err), 32'd0);

        // Back to IDLE via reset, then invalid counts 0 and 65
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check("idle_again", 32'(dbg_state), 32'(IDLE));
        we0 = we_cnt;
        start_load(7'd0);
        check("cnt0_err", 32'(err), 32'd1);
        check("cnt0_state", 32'(dbg_state), 32'(IDLE));
        step();
        check("cnt0_err_clr", 32'(err), 32'd0);
        start_load(7'd65);
        check("cnt65_err", 32'(err), 32'd1);
        check("cnt65_state", 32'(dbg_state), 32'(IDLE));
        step();
        check("cnt65_err_clr", 32'(err), 32'd0);
        check("bad_no_we", 32'(we_cnt - we0), 32'd0);

        // Full 64-word load; run_req asserted alongside ld_start must lose
        we0 = we_cnt;
        run_req = 1'b1;
        start_load(7'd64);
        run_req = 1'b0;
        check("ld64_state", 32'(dbg_state), 32'(LOAD));
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA000_0000 + 32'(i);
            #1;
            if (i == 0 || i == 63) begin
                check("ld64_addr", 32'(mem_addr), 32'(i));
                check("ld64_we", 32'(mem_we), 32'd1);
                check("ld64_in_load", 32'(dbg_state), 32'(LOAD));
            end
            step();
        end
        check("ld64_flush_state", 32'(dbg_state), 32'(FLUSH));
        check("ld64_flush_we", 32'(mem_we), 32'd0);
        ld_valid = 1'b0;
        check("ld64_we_cycles", 32'(we_cnt - we0), 32'd64);
        check("ld64_mem0", mem[0], 32'hA000_0000);
        check("ld64_mem63", mem[63], 32'hA000_003F);
        step();
        check("ld64_run_state", 32'(dbg_state), 32'(RUN));

        // Reset in the middle of a 4-word load
        start_load(7'd4);
        push_word(32'h1111_0000);
        push_word(32'h1111_0001);
        check("abort_pre_state", 32'(dbg_state), 32'(LOAD));
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_stall", 32'(cpu_stall), 32'd1);
        check("abort_cpu_rst", 32'(cpu_rst), 32'd0);
        check("abort_ready", 32'(ld_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_post_state", 32'(dbg_state), 32'(IDLE));
        check("abort_post_cpu_rst", 32'(cpu_rst), 32'd0);
        check("abort_mem1", mem[1], 32'h1111_0001);
        check("abort_mem2", mem[2], 32'hA000_0002);

`ifdef IMEM_LOAD_CHECKSUM_EN
        // 1 + 0xFFFFFFFF wraps to 0
        ld_csum = 32'h0000_0000;
        start_load(7'd2);
        push_word(32'h0000_0001);
        push_word(32'hFFFF_FFFF);
        check("csum_ok_state", 32'(dbg_state), 32'(FLUSH));
        check("csum_ok_err", 32'(err), 32'd0);
        step();
        ld_csum = 32'h0000_0001;
        start_load(7'd2);
        push_word(32'h0000_0001);
        push_word(32'hFFFF_FFFF);
        check("csum_bad_state", 32'(dbg_state), 32'(IDLE));
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd0);
        step();
        check("csum_bad_err_clr", 32'(err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction memory depth in words.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning word-address width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ld_start, input, 1, request to begin a program load.
REQ-006 SHALL have port ld_count, input, ADDR_W+1, number of words to load; sampled with ld_start.
REQ-007 SHALL have port ld_valid, input, 1, loader word valid.
REQ-008 SHALL have port ld_data, input, 32, loader instruction word.
REQ-009 SHALL have port ld_ready, output, 1, controller accepts the loader word this cycle.
REQ-010 SHALL have port run_req, input, 1, start the CPU on the existing memory image without loading.
REQ-011 SHALL have port fetch_addr, input, ADDR_W, CPU fetch word address.
REQ-012 SHALL have port mem_addr, output, ADDR_W, address driven to instruction memory.
REQ-013 SHALL have port mem_we, output, 1, instruction memory write enable.
REQ-014 SHALL have port mem_wdata, output, 32, instruction memory write data.
REQ-015 SHALL have port cpu_stall, output, 1, freezes the CPU PC and register writes.
REQ-016 SHALL have port cpu_rst, output, 1, one-cycle synchronous PC-clear pulse to the CPU.
REQ-017 SHALL have port busy, output, 1, high in LOAD and FLUSH.
REQ-018 SHALL have port err, output, 1, one-cycle error pulse.

Function
REQ-019 SHALL implement states IDLE, LOAD, FLUSH, RUN.
REQ-020 IDLE: cpu_stall=1; ld_start with 1<=ld_count<=DEPTH -> LOAD, word counter cleared; ld_start with ld_count=0 or >DEPTH -> err pulse next cycle, stay IDLE; run_req (without ld_start) -> FLUSH.
REQ-021 ld_start and run_req high together SHALL give priority to ld_start.
REQ-022 LOAD: ld_ready=1, cpu_stall=1; mem_we=ld_valid combinationally; mem_addr=counter, mem_wdata=ld_data; counter increments on each accepted word.
REQ-023 LOAD SHALL exit to FLUSH in the cycle after accepting the word at index ld_count-1; ld_count=DEPTH writes address DEPTH-1 last without counter wrap to 0.
REQ-024 ld_start during LOAD, FLUSH SHALL be ignored; ld_valid outside LOAD SHALL be ignored (ld_ready=0, mem_we=0).
REQ-025 FLUSH: exactly one cycle, cpu_stall=1, cpu_rst=1, then RUN.
REQ-026 RUN: cpu_stall=0, mem_we=0, mem_addr=fetch_addr; ld_start (valid count) -> LOAD with same rules as IDLE; invalid count -> err pulse, stay RUN; run_req ignored.
REQ-027 In all states other than LOAD, mem_addr SHALL equal fetch_addr combinationally.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, counter=0, ld_ready=0, mem_we=0, mem_wdata=0, cpu_stall=1, cpu_rst=0, busy=0, err=0.
REQ-029 Reset asserted mid-LOAD SHALL abort the load; words already written remain in memory; no FLUSH occurs.

Configuration
REQ-030 Macro IMEM_LOAD_CHECKSUM_EN SHALL, when defined, add input ld_csum (32) sampled with ld_start, and a 32-bit modulo-2^32 sum of accepted words cleared on LOAD entry.
REQ-031 With IMEM_LOAD_CHECKSUM_EN, sum mismatch after the last word SHALL pulse err and go to IDLE instead of FLUSH; match proceeds to FLUSH.
REQ-032 Without IMEM_LOAD_CHECKSUM_EN, no ld_csum port exists and LOAD always proceeds to FLUSH.

Verification
REQ-033 Reset, then run_req=1 one cycle -> FLUSH one cycle with cpu_rst=1, then RUN with cpu_stall=0 and mem_addr following fetch_addr=5.
REQ-034 ld_start, ld_count=3, words 0x00002083/0x00802103/0x00C02183 with ld_valid gap of 2 cycles after first -> mem_we exactly 3 cycles at addresses 0,1,2, then FLUSH, RUN.
REQ-035 ld_count=0 and ld_count=65 in IDLE -> err pulse each, state stays IDLE, mem_we never asserted.
REQ-036 ld_count=64 full load -> last write at address 63, counter never wraps, FLUSH follows.
REQ-037 rst_n low after second accepted word of 4-word load -> IDLE immediately, cpu_stall=1, no cpu_rst pulse.
REQ-038 With IMEM_LOAD_CHECKSUM_EN, 2 words 0x00000001,0xFFFFFFFF, ld_csum=0x00000000 -> FLUSH; ld_csum=0x00000001 -> err pulse, IDLE.
